// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// States: IDLE (waiting) | RUN (iterating, busy) | DONE (result valid for one cycle).
module div_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           valid,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);

    localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N:0]     p_q, p_d;
    logic [2*N-1:0] quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] q_res_q, q_res_d;
    logic [N-1:0]   r_res_q, r_res_d;
    logic           dz_q, dz_d;

    // Partial remainder stays below the divisor, so N+1 bits always hold the shifted value.
    logic [N:0] p_shift;
    logic [N:0] p_sub;
    logic       q_bit;

    assign p_shift = {p_q[N-1:0], dvd_q[2*N-1]};
    assign p_sub   = p_shift - {1'b0, dvs_q};
    assign q_bit   = (p_shift >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_res_d = q_res_q;
        r_res_d = r_res_q;
        dz_d    = dz_q;
        busy    = 1'b0;
        valid   = 1'b0;

        case (state_q)
            RUN: begin
                busy  = 1'b1;
                dvd_d = {dvd_q[2*N-2:0], 1'b0};
                p_d   = q_bit ? p_sub : p_shift;
                quo_d = {quo_q[2*N-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    q_res_d = quo_d;
                    r_res_d = p_d[N-1:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the DONE->IDLE step so back-to-back requests leave no gap.
        if (start && (state_q != RUN)) begin
            dvd_d = a;
            dvs_d = b;
            p_d   = '0;
            quo_d = '0;
            cnt_d = '0;
            if (b == '0) begin
                q_res_d = '1;
                r_res_d = '0;
                dz_d    = 1'b1;
                state_d = DONE;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_res_q <= '0;
            r_res_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_res_q <= q_res_d;
            r_res_q <= r_res_d;
            dz_q    <= dz_d;
        end
    end

    assign q  = q_res_q;
    assign r  = r_res_q;
    assign dz = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (N=4): latency, boundaries, divide-by-zero, ignored start, reset abort, streaming.
module tb_div_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           busy;
    logic           valid;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dz;

    int checks = 0;
    int errors = 0;

    div_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .valid (valid),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launches one request and returns at the negedge of its valid cycle.
    task automatic run_op(input string tag, input int av, input int bv,
                          input int exp_q, input int exp_r, input int exp_dz, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        a     = av[2*N-1:0];
        b     = bv[N-1:0];
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!valid && lat < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_valid"}, {31'd0, valid}, 1);
        check({tag, "_q"}, {24'd0, q}, exp_q);
        check({tag, "_r"}, {28'd0, r}, exp_r);
        check({tag, "_dz"}, {31'd0, dz}, exp_dz);
    endtask

    initial begin
        int vcnt;
        int vq;
        int vr;
        int exp_q [4];
        int exp_r [4];
        int idx;
        int gap;
        int busy_bad;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_q", {24'd0, q}, 0);
        check("rst_r", {28'd0, r}, 0);
        check("rst_dz", {31'd0, dz}, 0);

        run_op("d200_7", 200, 7, 28, 4, 0, 9);
        @(negedge clk);
        check("hold_valid_low", {31'd0, valid}, 0);
        check("hold_q", {24'd0, q}, 28);
        check("hold_r", {28'd0, r}, 4);

        run_op("d255_1", 255, 1, 255, 0, 0, 9);
        run_op("d5_15", 5, 15, 0, 5, 0, 9);
        run_op("d0_9", 0, 9, 0, 0, 0, 9);
        run_op("d255_15", 255, 15, 17, 0, 0, 9);

        run_op("d100_0", 100, 0, 255, 0, 1, 1);
        run_op("d9_2", 9, 2, 4, 1, 0, 9);

        // Second request during RUN must be dropped.
        @(negedge clk);
        a = 8'd200; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'd50; b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vcnt = 0; vq = -1; vr = -1;
        repeat (20) begin
            @(negedge clk);
            if (valid) begin
                vcnt++;
                vq = int'(q);
                vr = int'(r);
            end
        end
        check("ignore_valid_count", vcnt, 1);
        check("ignore_q", vq, 28);
        check("ignore_r", vr, 4);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 8'd200; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_valid", {31'd0, valid}, 0);
        check("abort_q", {24'd0, q}, 0);
        check("abort_r", {28'd0, r}, 0);
        check("abort_dz", {31'd0, dz}, 0);
        vcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        run_op("d100_3", 100, 3, 33, 1, 0, 9);

        // Start held high with alternating operands.
        exp_q[0] = 28; exp_r[0] = 4;
        exp_q[1] = 12; exp_r[1] = 5;
        exp_q[2] = 28; exp_r[2] = 4;
        exp_q[3] = 12; exp_r[3] = 5;
        @(negedge clk);
        a = 8'd200; b = 4'd7; start = 1'b1;
        idx = 0; gap = 0; busy_bad = 0;
        while (idx < 4 && gap < 40) begin
            @(negedge clk);
            gap++;
            if (valid) begin
                if (busy) busy_bad++;
                check($sformatf("stream%0d_q", idx), {24'd0, q}, exp_q[idx]);
                check($sformatf("stream%0d_r", idx), {28'd0, r}, exp_r[idx]);
                if (idx > 0) check($sformatf("stream%0d_gap", idx), gap, 9);
                idx++;
                gap = 0;
                if (idx == 4) start = 1'b0;
                else if (idx % 2 == 1) begin a = 8'd77; b = 4'd6; end
                else begin a = 8'd200; b = 4'd7; end
            end else if (!busy) begin
                busy_bad++;
            end
        end
        start = 1'b0;
        check("stream_count", idx, 4);
        check("stream_busy_only_drops_on_valid", busy_bad, 0);
        @(negedge clk);
        check("stream_end_idle", {31'd0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
